pcie_rq_seq_tracker: RTL
========================

# pcie_rq_seq_tracker

Tracks PCIe requester-request (RQ) TLPs from issue on the user side until the PCIe hard IP reports them transmitted via its RQ sequence-number return ports (`pcie_rq_seq_num_0/1` plus valids). Sits between the DMA engine in `fpga_core` and the `s_axis_rq_seq_num_*` inputs. It does three things:
- gates new issues so sequence numbers are never reused while in flight;
- keeps an outstanding count;
- measures issue-to-transmit latency (min / max / sum) for the DMA benchmark.

## Interface
Parameters:
- `RQ_SEQ_NUM_WIDTH`, 6, sequence-number width; tracker holds 2^W entries
- `MAX_OUTSTANDING`, 32, issue limit (1 .. 2^RQ_SEQ_NUM_WIDTH)
- `TS_WIDTH`, 16, timestamp/latency width
- `STAT_WIDTH`, 32, issue/complete counter width
- `SUM_WIDTH`, 48, latency accumulator width

Ports:
- `clk`  in  1  PCIe user clock, 250 MHz
- `rst`  in  1  synchronous, active-high reset
- `s_issue_seq`  in  RQ_SEQ_NUM_WIDTH  sequence number of TLP being issued
- `s_issue_valid`  in  1  issue request
- `s_issue_ready`  out  1  issue accepted when valid & ready
- `s_axis_rq_seq_num_0`  in  RQ_SEQ_NUM_WIDTH  returned seq num, port 0
- `s_axis_rq_seq_num_valid_0`  in  1  port 0 valid
- `s_axis_rq_seq_num_1`  in  RQ_SEQ_NUM_WIDTH  returned seq num, port 1
- `s_axis_rq_seq_num_valid_1`  in  1  port 1 valid
- `stat_clear`  in  1  one-cycle pulse; clears statistics only
- `stat_outstanding`  out  RQ_SEQ_NUM_WIDTH+1  in-flight count
- `stat_issue_count`  out  STAT_WIDTH  accepted issues, wrapping
- `stat_complete_count`  out  STAT_WIDTH  matched returns, wrapping
- `stat_lat_min`  out  TS_WIDTH  minimum latency, cycles
- `stat_lat_max`  out  TS_WIDTH  maximum latency, cycles
- `stat_lat_sum`  out  SUM_WIDTH  latency sum, wrapping
- `err_unexpected`  out  1  sticky; a return hit a non-outstanding entry

## Operation
- State:
  - `inflight[2^W]` bit vector;
  - `ts[2^W]` register array, TS_WIDTH each;
  - free-running `now` counter, TS_WIDTH, wrapping.
- `s_issue_ready` is registered:
  - high when `stat_outstanding < MAX_OUTSTANDING`.
  - Issue of a seq whose `inflight` bit is set: accepted by the handshake, but dropped (no state change), and `err_unexpected` set.
- Issue accept:
  - set `inflight[seq]`;
  - `ts[seq] <= now`;
  - outstanding +1;
  - `stat_issue_count` +1.
- Return on either port with `inflight[seq]` set:
  - clear the bit;
  - latency = `now - ts[seq]` modulo 2^TS_WIDTH;
  - outstanding −1;
  - `stat_complete_count` +1;
  - min / max / sum updated.
- Return with the bit clear: `err_unexpected <= 1`; nothing else changes.
- Both ports valid in one cycle: both processed. If they carry the same seq, port 0 matches and port 1 is flagged unexpected.
- Issue and return in the same cycle: net outstanding change = issues − matched returns (range −2 .. +1). Same-seq issue/return in one cycle: the return is processed against the prior state, then the issue sets the bit and overwrites `ts`.
- `stat_clear`:
  - counters and sum → 0, min → all-ones, max → 0, `err_unexpected` → 0;
  - `inflight`, `ts` and outstanding are untouched.
  - Events in the same cycle as clear are counted after the clear.
- Latency min/max with two matched returns in one cycle: both considered, result = min/max over old value and both latencies.

## Timing
- Returns: the cycle-N strobe updates outstanding, the counters and `inflight` at N+1. Latency stats are pipelined one stage, updating at N+2.
- Issue: `inflight` / `ts` / outstanding update at N+1. `s_issue_ready` reflects the new outstanding value at N+1, so ready may drop one cycle after the limit is reached. No over-issue occurs because ready is computed with a pending issue counted.
- Reset values:
  - `s_issue_ready` 0 during reset, 1 the cycle after;
  - `stat_outstanding` 0, counts 0, sum 0, `stat_lat_min` all-ones, `stat_lat_max` 0, `err_unexpected` 0;
  - `inflight` all 0, `now` 0.
- Reset mid-operation discards all in-flight state. Later returns for pre-reset issues flag `err_unexpected`.
- Latency over 2^TS_WIDTH−1 cycles aliases (documented limitation).

## Test plan
- Issue seq 5 at cycle 10, return on port 0 at cycle 30 → outstanding 1→0, `stat_lat_min` = `stat_lat_max` = `stat_lat_sum` = 20, complete 1.
- Issue seq 1,2 back-to-back, return both in one cycle on ports 0/1 → outstanding 2→0 in one cycle, complete +2, sum = both latencies.
- Issue 32 distinct seqs with MAX_OUTSTANDING=32 → `s_issue_ready` low, 33rd held; one return → ready high next cycle, 33rd accepted.
- Return seq 7 never issued → `err_unexpected` 1, counts unchanged; `stat_clear` → 0.
- Issue seq 3 twice without return → second dropped, `err_unexpected` 1, outstanding 1.
- Assert `rst` with 4 in flight → all outputs at reset values next cycle; return of old seq → `err_unexpected` 1.

Source files
------------

// File: rtl/pcie_rq_seq_tracker_if.sv
// pcie_rq_seq_tracker_if: issue handshake and RQ sequence-number return bus
interface pcie_rq_seq_tracker_if #(
    parameter int RQ_SEQ_NUM_WIDTH = 6
);
    logic [RQ_SEQ_NUM_WIDTH-1:0] s_issue_seq;
    logic                        s_issue_valid;
    logic                        s_issue_ready;
    logic [RQ_SEQ_NUM_WIDTH-1:0] s_axis_rq_seq_num_0;
    logic                        s_axis_rq_seq_num_valid_0;
    logic [RQ_SEQ_NUM_WIDTH-1:0] s_axis_rq_seq_num_1;
    logic                        s_axis_rq_seq_num_valid_1;
    modport master (
        output s_issue_seq, s_issue_valid,
        output s_axis_rq_seq_num_0, s_axis_rq_seq_num_valid_0,
        output s_axis_rq_seq_num_1, s_axis_rq_seq_num_valid_1,
        input  s_issue_ready
    );
    modport slave (
        input  s_issue_seq, s_issue_valid,
        input  s_axis_rq_seq_num_0, s_axis_rq_seq_num_valid_0,
        input  s_axis_rq_seq_num_1, s_axis_rq_seq_num_valid_1,
        output s_issue_ready
    );
endinterface

// File: rtl/pcie_rq_seq_tracker.sv
// pcie_rq_seq_tracker: gates RQ issues, counts in-flight TLPs and measures issue-to-transmit latency
module pcie_rq_seq_tracker #(
    parameter int RQ_SEQ_NUM_WIDTH = 6,
    parameter int MAX_OUTSTANDING  = 32,
    parameter int TS_WIDTH         = 16,
    parameter int STAT_WIDTH       = 32,
    parameter int SUM_WIDTH        = 48
) (
    input  logic                        clk,
    input  logic                        rst,
    pcie_rq_seq_tracker_if.slave        rq,
    input  logic                        stat_clear,
    output logic [RQ_SEQ_NUM_WIDTH:0]   stat_outstanding,
    output logic [STAT_WIDTH-1:0]       stat_issue_count,
    output logic [STAT_WIDTH-1:0]       stat_complete_count,
    output logic [TS_WIDTH-1:0]         stat_lat_min,
    output logic [TS_WIDTH-1:0]         stat_lat_max,
    output logic [SUM_WIDTH-1:0]        stat_lat_sum,
    output logic                        err_unexpected
);
    localparam int N  = 1 << RQ_SEQ_NUM_WIDTH;
    localparam int OW = RQ_SEQ_NUM_WIDTH + 1;

    logic [RQ_SEQ_NUM_WIDTH-1:0] iseq, r0, r1;
    logic                        iv, v0, v1;
    logic [N-1:0]                inflight, inflight_n;
    logic [TS_WIDTH-1:0]         ts [N];
    logic [TS_WIDTH-1:0]         now;
    logic [OW-1:0]               outstanding_n;
    logic                        issue_fire, issue_dup, issue_acc, m0, m1, u0, u1;
    logic [TS_WIDTH-1:0]         lat0, lat1, p_lat0, p_lat1;
    logic                        p_m0, p_m1;
    logic [TS_WIDTH-1:0]         min_a, min_b, min_n, max_a, max_b, max_n;
    logic [SUM_WIDTH-1:0]        sum_n;

    assign iseq = rq.s_issue_seq;
    assign iv   = rq.s_issue_valid;
    assign r0   = rq.s_axis_rq_seq_num_0;
    assign v0   = rq.s_axis_rq_seq_num_valid_0;
    assign r1   = rq.s_axis_rq_seq_num_1;
    assign v1   = rq.s_axis_rq_seq_num_valid_1;

    // Match returns against prior state, then let the issue see the post-return bitmap
    always_comb begin
        issue_fire = iv && rq.s_issue_ready;
        m0 = v0 && inflight[r0];
        m1 = v1 && inflight[r1] && !(v0 && r0 == r1);
        u0 = v0 && !m0;
        u1 = v1 && !m1;
        issue_dup = inflight[iseq] && !(m0 && r0 == iseq) && !(m1 && r1 == iseq);
        issue_acc = issue_fire && !issue_dup;
        lat0 = now - ts[r0];
        lat1 = now - ts[r1];
        inflight_n = inflight;
        if (m0) inflight_n[r0] = 1'b0;
        if (m1) inflight_n[r1] = 1'b0;
        if (issue_acc) inflight_n[iseq] = 1'b1;
        outstanding_n = stat_outstanding + OW'(issue_acc) - OW'(m0) - OW'(m1);
        min_a = stat_clear ? '1 : stat_lat_min;
        min_b = (p_m0 && p_lat0 < min_a) ? p_lat0 : min_a;
        min_n = (p_m1 && p_lat1 < min_b) ? p_lat1 : min_b;
        max_a = stat_clear ? '0 : stat_lat_max;
        max_b = (p_m0 && p_lat0 > max_a) ? p_lat0 : max_a;
        max_n = (p_m1 && p_lat1 > max_b) ? p_lat1 : max_b;
        sum_n = (stat_clear ? '0 : stat_lat_sum)
              + (p_m0 ? SUM_WIDTH'(p_lat0) : '0)
              + (p_m1 ? SUM_WIDTH'(p_lat1) : '0);
    end

    // Timestamp capture for accepted issues; contents are don't-care until the bit is set
    always_ff @(posedge clk) begin
        if (issue_acc) ts[iseq] <= now;
    end

    // Tracking state, counters, registered ready and the one-stage latency pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight            <= '0;
            now                 <= '0;
            stat_outstanding    <= '0;
            rq.s_issue_ready    <= 1'b0;
            stat_issue_count    <= '0;
            stat_complete_count <= '0;
            stat_lat_min        <= '1;
            stat_lat_max        <= '0;
            stat_lat_sum        <= '0;
            err_unexpected      <= 1'b0;
            p_m0                <= 1'b0;
            p_m1                <= 1'b0;
            p_lat0              <= '0;
            p_lat1              <= '0;
        end else begin
            inflight            <= inflight_n;
            now                 <= now + 1'b1;
            stat_outstanding    <= outstanding_n;
            rq.s_issue_ready    <= outstanding_n < OW'(MAX_OUTSTANDING);
            stat_issue_count    <= (stat_clear ? '0 : stat_issue_count) + STAT_WIDTH'(issue_acc);
            stat_complete_count <= (stat_clear ? '0 : stat_complete_count)
                                 + STAT_WIDTH'(m0) + STAT_WIDTH'(m1);
            stat_lat_min        <= min_n;
            stat_lat_max        <= max_n;
            stat_lat_sum        <= sum_n;
            err_unexpected      <= (err_unexpected && !stat_clear) || u0 || u1
                                 || (issue_fire && issue_dup);
            p_m0                <= m0;
            p_m1                <= m1;
            p_lat0              <= lat0;
            p_lat1              <= lat1;
        end
    end
endmodule
